// File: rtl/aes_vector_sequencer_if.sv
// rtl/aes_vector_sequencer_if.sv - vector stream and cipher-core bus bundle for aes_vector_sequencer
interface aes_vector_sequencer_if #(
    parameter int W = 128
);
    logic         vec_valid;
    logic         vec_ready;
    logic [W-1:0] vec_key;
    logic [W-1:0] vec_pt;
    logic [W-1:0] vec_exp;
    logic         aes_ld;
    logic [W-1:0] aes_key;
    logic [W-1:0] aes_text_in;
    logic         aes_done;
    logic [W-1:0] aes_text_out;

    // Environment side: supplies vectors and hosts the cipher core
    modport master (
        output vec_valid, vec_key, vec_pt, vec_exp, aes_done, aes_text_out,
        input  vec_ready, aes_ld, aes_key, aes_text_in
    );

    // Sequencer side: consumes vectors and drives the cipher core
    modport slave (
        input  vec_valid, vec_key, vec_pt, vec_exp, aes_done, aes_text_out,
        output vec_ready, aes_ld, aes_key, aes_text_in
    );
endinterface

// File: rtl/aes_vector_sequencer.sv
// rtl/aes_vector_sequencer.sv - stimulus/check engine driving one aes_cipher_top instance
module aes_vector_sequencer #(
    parameter int W       = 128,
    parameter int REPEAT  = 1,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr_cnt,
    aes_vector_sequencer_if.slave bus,
    output logic                  busy,
    output logic                  res_valid,
    output logic                  res_pass,
    output logic                  res_timeout,
    output logic [W-1:0]          res_ct,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [CNT_W-1:0]      to_cnt
);
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int REP_W = (REPEAT > 2) ? $clog2(REPEAT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CHECK} state_t;

    state_t           state;
    state_t           state_nx;
    logic [W-1:0]     key_q;
    logic [W-1:0]     pt_q;
    logic [W-1:0]     exp_q;
    logic [REP_W-1:0] rep;
    logic [TMR_W-1:0] timer;
    logic             done_q;
    logic             accept;
    logic             done_rise;
    logic             tmr_expired;
    logic             more_reps;

    assign accept      = (state == S_IDLE) & enable & bus.vec_valid;
    // A done level that is already high when WAIT starts never produces a rise
    assign done_rise   = bus.aes_done & ~done_q;
    assign tmr_expired = (timer == TMR_LAST);
    // A timed-out run abandons whatever repeats were left
    assign more_reps   = ~res_timeout & (rep != REP_LAST);

    assign bus.aes_key     = key_q;
    assign bus.aes_text_in = pt_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; completion takes priority over timer expiry
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT:   if (done_rise || tmr_expired) state_nx = S_CHECK;
            S_CHECK:  state_nx = more_reps ? S_LAUNCH : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Strobes decoded purely from the current state
    always_comb begin
        bus.vec_ready = 1'b0;
        bus.aes_ld    = 1'b0;
        res_valid     = 1'b0;
        case (state)
            S_IDLE:   bus.vec_ready = enable;
            S_LAUNCH: bus.aes_ld    = 1'b1;
            S_CHECK:  res_valid     = 1'b1;
            default:  ;
        endcase
    end

    // Vector latch, repeat/timer bookkeeping and result capture (held between strobes)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q       <= '0;
            pt_q        <= '0;
            exp_q       <= '0;
            rep         <= '0;
            timer       <= '0;
            done_q      <= 1'b0;
            busy        <= 1'b0;
            res_pass    <= 1'b0;
            res_timeout <= 1'b0;
            res_ct      <= '0;
        end else begin
            done_q <= bus.aes_done;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        key_q <= bus.vec_key;
                        pt_q  <= bus.vec_pt;
                        exp_q <= bus.vec_exp;
                        rep   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_LAUNCH: timer <= '0;
                S_WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (done_rise) begin
                        res_ct      <= bus.aes_text_out;
                        res_pass    <= (bus.aes_text_out == exp_q);
                        res_timeout <= 1'b0;
                    end else if (tmr_expired) begin
                        res_ct      <= '0;
                        res_pass    <= 1'b0;
                        res_timeout <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (more_reps) begin
                        rep <= rep + REP_W'(1);
                    end else begin
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating result counters; a clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            to_cnt   <= '0;
        end else if (clr_cnt) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            to_cnt   <= '0;
        end else if (state == S_CHECK) begin
            if (res_timeout) begin
                if (to_cnt != '1) to_cnt <= to_cnt + CNT_W'(1);
            end else if (res_pass) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_aes_vector_sequencer.sv
// tb/tb_aes_vector_sequencer.sv - timeline-model bench for aes_vector_sequencer with stub cipher cores
module tb_aes_vector_sequencer;
    localparam int W  = 128;
    localparam int NC = 4096;
    localparam int TO = 64;
    localparam logic [W-1:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] FPT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [W-1:0] SMIX = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [W-1:0] K2   = 128'h0;
    localparam logic [W-1:0] P2   = 128'h1;
    localparam logic [W-1:0] E2   = 128'h0123456789abcdef_fedcba9876543211;

    logic clk;
    logic rst_n;
    logic [1:0] en, clr, vv;
    logic [1:0][W-1:0] vkey, vpt, vexp;
    int lat [2];

    logic [1:0] o_ready, o_ld, o_busy, o_rv, o_rp, o_rt;
    logic [1:0][W-1:0] o_ct, o_key, o_pt;
    logic [1:0][15:0] o_pc, o_fc, o_tc;

    int cyc;
    int n_cmp;
    int n_bad;

    // timeline model: per DUT, per cycle
    bit m_ld [2][NC];
    bit m_res [2][NC];
    bit m_busy [2][NC];
    bit m_pass [2][NC];
    bit m_to [2][NC];
    logic [W-1:0] m_ct [2][NC];
    logic [W-1:0] m_key [2][NC];
    logic [W-1:0] m_pt [2][NC];
    int m_last_r [2];
    int mc [2][3];
    bit lp [2];
    bit lt [2];
    logic [W-1:0] lc [2];

    function automatic logic [W-1:0] stub_ct(input logic [W-1:0] k, input logic [W-1:0] p);
        if (k == FKEY && p == FPT) return FCT;
        return k ^ p ^ SMIX;
    endfunction

    function automatic int rep_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 3 : 65535;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int CW = (g == 0) ? 2 : 16;
        aes_vector_sequencer_if #(.W(W)) vif ();
        logic [CW-1:0] pc, fc, tc;
        logic done_r, pend;
        logic [W-1:0] out_r, ct_r;
        int cnt;

        assign vif.vec_valid    = vv[g];
        assign vif.vec_key      = vkey[g];
        assign vif.vec_pt       = vpt[g];
        assign vif.vec_exp      = vexp[g];
        assign vif.aes_done     = done_r;
        assign vif.aes_text_out = out_r;
        assign o_ready[g]       = vif.vec_ready;
        assign o_ld[g]          = vif.aes_ld;
        assign o_key[g]         = vif.aes_key;
        assign o_pt[g]          = vif.aes_text_in;
        assign o_pc[g]          = 16'(pc);
        assign o_fc[g]          = 16'(fc);
        assign o_tc[g]          = 16'(tc);

        aes_vector_sequencer #(
            .W(W), .REPEAT((g == 0) ? 1 : 3), .TIMEOUT(TO), .CNT_W(CW)
        ) dut (
            .clk(clk), .rst(rst_n), .enable(en[g]), .clr_cnt(clr[g]), .bus(vif.slave),
            .busy(o_busy[g]), .res_valid(o_rv[g]), .res_pass(o_rp[g]), .res_timeout(o_rt[g]),
            .res_ct(o_ct[g]), .pass_cnt(pc), .fail_cnt(fc), .to_cnt(tc)
        );

        // stub core: one-cycle done pulse lat[g] cycles after ld (lat 0 = never)
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                done_r <= 1'b0; pend <= 1'b0; cnt <= 0; out_r <= '0; ct_r <= '0;
            end else begin
                done_r <= 1'b0;
                if (vif.aes_ld) begin
                    ct_r <= stub_ct(vif.aes_key, vif.aes_text_in);
                    pend <= 1'b0;
                    if (lat[g] == 1) begin
                        done_r <= 1'b1;
                        out_r  <= stub_ct(vif.aes_key, vif.aes_text_in);
                    end else if (lat[g] > 1) begin
                        cnt  <= lat[g] - 1;
                        pend <= 1'b1;
                    end
                end else if (pend) begin
                    if (cnt == 1) begin
                        done_r <= 1'b1;
                        out_r  <= ct_r;
                        pend   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, i, cyc, got, exp);
        end
    endtask

    // Accept at the edge ending cycle a: runs of (ld, wait, check) back to back
    task automatic schedule(input int i, input int a);
        int c;
        int r;
        bit to;
        logic [W-1:0] ct;
        c  = a + 1;
        ct = stub_ct(vkey[i], vpt[i]);
        for (int k = 0; k < rep_of(i); k++) begin
            to = (lat[i] == 0) || (lat[i] > TO);
            r  = to ? c + 1 + TO : c + 1 + lat[i];
            if (r >= NC) break;
            m_ld[i][c] = 1'b1;
            for (int t = c; t <= r; t++) begin
                m_busy[i][t] = 1'b1;
                m_key[i][t]  = vkey[i];
                m_pt[i][t]   = vpt[i];
            end
            m_res[i][r]  = 1'b1;
            m_to[i][r]   = to;
            m_pass[i][r] = !to && (ct == vexp[i]);
            m_ct[i][r]   = to ? '0 : ct;
            m_last_r[i]  = r;
            if (to) break;
            c = r + 1;
        end
    endtask

    initial begin : compare
        int k;
        forever begin
            @(negedge clk);
            k = cyc;
            if (k < NC) begin
                for (int i = 0; i < 2; i++) begin
                    if (!rst_n) begin
                        for (int t = k; t < NC; t++) begin
                            m_ld[i][t] = 1'b0; m_res[i][t] = 1'b0; m_busy[i][t] = 1'b0;
                        end
                        mc[i][0] = 0; mc[i][1] = 0; mc[i][2] = 0;
                        lp[i] = 1'b0; lt[i] = 1'b0; lc[i] = '0;
                        chk("rst_ld", i, W'(o_ld[i]), '0);
                        chk("rst_busy", i, W'(o_busy[i]), '0);
                        chk("rst_res_valid", i, W'(o_rv[i]), '0);
                        chk("rst_res_ct", i, o_ct[i], '0);
                        chk("rst_pass_cnt", i, W'(o_pc[i]), '0);
                        chk("rst_fail_cnt", i, W'(o_fc[i]), '0);
                        chk("rst_to_cnt", i, W'(o_tc[i]), '0);
                    end else begin
                        if (m_res[i][k]) begin
                            lp[i] = m_pass[i][k]; lt[i] = m_to[i][k]; lc[i] = m_ct[i][k];
                        end
                        chk("aes_ld", i, W'(o_ld[i]), W'(m_ld[i][k]));
                        chk("busy", i, W'(o_busy[i]), W'(m_busy[i][k]));
                        chk("res_valid", i, W'(o_rv[i]), W'(m_res[i][k]));
                        chk("vec_ready", i, W'(o_ready[i]), W'(en[i] && !m_busy[i][k]));
                        chk("res_pass", i, W'(o_rp[i]), W'(lp[i]));
                        chk("res_timeout", i, W'(o_rt[i]), W'(lt[i]));
                        chk("res_ct", i, o_ct[i], lc[i]);
                        chk("pass_cnt", i, W'(o_pc[i]), W'(mc[i][0]));
                        chk("fail_cnt", i, W'(o_fc[i]), W'(mc[i][1]));
                        chk("to_cnt", i, W'(o_tc[i]), W'(mc[i][2]));
                        if (m_busy[i][k]) begin
                            chk("aes_key", i, o_key[i], m_key[i][k]);
                            chk("aes_text_in", i, o_pt[i], m_pt[i][k]);
                        end
                        if (vv[i] && en[i] && !m_busy[i][k]) schedule(i, k);
                        if (clr[i]) begin
                            mc[i][0] = 0; mc[i][1] = 0; mc[i][2] = 0;
                        end else if (m_res[i][k]) begin
                            int s;
                            s = m_to[i][k] ? 2 : (m_pass[i][k] ? 0 : 1);
                            if (mc[i][s] < cmax(i)) mc[i][s]++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (cyc < NC && m_busy[i][cyc] && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000 || cyc >= NC) chk("idle_bound", i, W'(1), W'(0));
    endtask

    task automatic send(input int i, input logic [W-1:0] k, input logic [W-1:0] p,
                        input logic [W-1:0] e, output int a);
        wait_idle(i);
        vkey[i] = k; vpt[i] = p; vexp[i] = e; vv[i] = 1'b1;
        a = cyc;
        tick();
        vv[i] = 1'b0;
    endtask

    task automatic until_cyc(input int t);
        int n;
        n = 0;
        while (cyc < t && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("cyc_bound", 0, W'(1), W'(0));
    endtask

    initial begin : drive
        int a;
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst_n = 1'b0; en = '0; clr = '0; vv = '0;
        vkey = '0; vpt = '0; vexp = '0;
        lat[0] = 10; lat[1] = 10;
        repeat (3) tick();
        rst_n = 1'b1;
        en = 2'b11;
        tick();

        // FIPS-197 vector, pass
        send(0, FKEY, FPT, FCT, a);
        wait_idle(0);
        chk("fips_result_cycle", 0, W'(m_last_r[0]), W'(a + 12));
        chk("fips_pass_cnt", 0, W'(o_pc[0]), W'(1));
        chk("fips_ct_held", 0, o_ct[0], FCT);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;

        // expected bit 0 flipped -> fail
        send(0, FKEY, FPT, FCT ^ W'(1), a);
        wait_idle(0);
        chk("flip_fail_cnt", 0, W'(o_fc[0]), W'(1));
        chk("flip_pass_cnt", 0, W'(o_pc[0]), W'(0));
        chk("flip_res_pass", 0, W'(o_rp[0]), W'(0));
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;

        // core never finishes -> timeout 64 cycles after WAIT entry
        lat[0] = 0;
        send(0, FKEY, FPT, FCT, a);
        wait_idle(0);
        chk("to_result_cycle", 0, W'(m_last_r[0]), W'(a + 66));
        chk("to_cnt_one", 0, W'(o_tc[0]), W'(1));
        chk("to_vec_ready", 0, W'(o_ready[0]), W'(1));

        // boundary: done on the last timer count wins, one later times out
        lat[0] = 64;
        send(0, FKEY, FPT, FCT, a);
        wait_idle(0);
        chk("lat64_pass_cnt", 0, W'(o_pc[0]), W'(1));
        lat[0] = 65;
        send(0, FKEY, FPT, FCT, a);
        wait_idle(0);
        chk("lat65_to_cnt", 0, W'(o_tc[0]), W'(2));
        repeat (4) tick();

        // saturation with CNT_W=2, then clear on the same cycle as a CHECK
        lat[0] = 10;
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        for (int n = 0; n < 5; n++) send(0, FKEY, FPT, FCT, a);
        wait_idle(0);
        chk("sat_pass_cnt", 0, W'(o_pc[0]), W'(3));
        send(0, FKEY, FPT, FCT, a);
        until_cyc(m_last_r[0]);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        wait_idle(0);
        chk("clr_over_inc", 0, W'(o_pc[0]), W'(0));

        // REPEAT=3, junk on vec_* while busy is ignored
        send(1, K2, P2, E2, a);
        vkey[1] = FKEY; vpt[1] = FPT; vexp[1] = '0; vv[1] = 1'b1;
        repeat (20) tick();
        vv[1] = 1'b0;
        wait_idle(1);
        chk("rep_result_cycle", 1, W'(m_last_r[1]), W'(a + 36));
        chk("rep_pass_cnt", 1, W'(o_pc[1]), W'(3));

        // REPEAT=3 with a dead core: single run, remaining repeats abandoned
        lat[1] = 0;
        send(1, K2, P2, E2, a);
        wait_idle(1);
        chk("rep_to_cycle", 1, W'(m_last_r[1]), W'(a + 66));
        chk("rep_to_cnt", 1, W'(o_tc[1]), W'(1));
        lat[1] = 10;
        repeat (4) tick();

        // enable dropped mid-vector: repeats finish, nothing new accepted
        send(1, FKEY, FPT, FCT, a);
        repeat (3) tick();
        en[1] = 1'b0;
        wait_idle(1);
        chk("en_pass_cnt", 1, W'(o_pc[1]), W'(6));
        vv[1] = 1'b1;
        repeat (3) tick();
        vv[1] = 1'b0;
        repeat (2) tick();
        chk("en_off_busy", 1, W'(o_busy[1]), W'(0));
        en[1] = 1'b1;

        // asynchronous reset during WAIT
        send(0, FKEY, FPT, FCT, a);
        until_cyc(a + 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_ld", 0, W'(o_ld[0]), W'(0));
        chk("async_busy", 0, W'(o_busy[0]), W'(0));
        chk("async_res_valid", 0, W'(o_rv[0]), W'(0));
        chk("async_pass_cnt", 1, W'(o_pc[1]), W'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(0, FKEY, FPT, FCT, a);
        wait_idle(0);
        chk("post_rst_pass_cnt", 0, W'(o_pc[0]), W'(1));
        chk("post_rst_ct", 0, o_ct[0], FCT);

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
